// File: rtl/rr_grant_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : rr_grant_arbiter_if
// Brief   : Request/grant bundle between requesters and the round-robin arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface rr_grant_arbiter_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_grant_arbiter
// Brief   : 8-way round-robin arbiter with hold timeout, one-hot + index grant.
// Revision: 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_grant_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit               HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             hold_hit;
    logic             holder_req;

    // Search upward from the slot after the last released requester, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign holder_req = bus.req[idx_q];
    assign hold_hit   = HOLD_EN && (cnt_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
                    idx_d   = pick;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.done || !holder_req || hold_hit) begin
                    // A forced release is flagged only when nothing else would have ended the grant.
                    timeout_d = hold_hit && !bus.done && holder_req;
                    ptr_d     = idx_q;
                    grant_d   = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N - 1);
            cnt_q     <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_grant_arbiter
// Brief   : Vector-table bench for rr_grant_arbiter with an expected-result queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

    typedef struct packed {
        logic [7:0] req;
        logic       done;
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       timeout;
    } vec_t;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       timeout;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    vec_t vecs[$];
    exp_t exp_q[$];

    rr_grant_arbiter_if #(.N(8), .IDX_W(3)) bus ();

    rr_grant_arbiter #(
        .N(8), .IDX_W(3), .HOLD_MAX(16), .CNT_W(5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t observe();
        exp_t o;
        o.grant   = bus.grant;
        o.idx     = bus.grant_idx;
        o.valid   = bus.grant_valid;
        o.timeout = bus.timeout;
        return o;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, required grant=%h idx=%0d valid=%b timeout=%b",
                     name, act.grant, act.idx, act.valid, act.timeout,
                     req_v.grant, req_v.idx, req_v.valid, req_v.timeout);
        end
    endtask

    function automatic void add(input logic [7:0] r, input logic d, input logic [7:0] g,
                                input logic [2:0] i, input logic t);
        vec_t v;
        v.req = r; v.done = d; v.grant = g; v.idx = i; v.valid = (g != 8'h00); v.timeout = t;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input string name, input logic [7:0] r, input logic d, input exp_t e);
        exp_t front;
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        front = exp_q.pop_front();
        check(name, observe(), front);
    endtask

    function automatic exp_t mk(input logic [7:0] g, input logic [2:0] i, input logic t);
        exp_t e;
        e.grant = g; e.idx = i; e.valid = (g != 8'h00); e.timeout = t;
        return e;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Single requester grant then release; done while idle is ignored.
        add(8'h01, 1'b0, 8'h01, 3'd0, 1'b0);
        add(8'h01, 1'b1, 8'h00, 3'd0, 1'b0);
        add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
        // Two requesters alternate with an idle cycle between grants.
        for (int k = 0; k < 2; k++) begin
            add(8'h84, 1'b0, 8'h04, 3'd2, 1'b0);
            add(8'h84, 1'b1, 8'h00, 3'd0, 1'b0);
            add(8'h84, 1'b0, 8'h80, 3'd7, 1'b0);
            add(8'h84, 1'b1, 8'h00, 3'd0, 1'b0);
        end
        add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        // All requesting: full rotation and wrap back to 0.
        for (int k = 0; k < 9; k++) begin
            add(8'hFF, 1'b0, 8'h01 << (k % 8), 3'(k % 8), 1'b0);
            add(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0);
        end
        add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        // Holder 3 drops its request; next winner is 5.
        add(8'h28, 1'b0, 8'h08, 3'd3, 1'b0);
        add(8'h28, 1'b0, 8'h08, 3'd3, 1'b0);
        add(8'h20, 1'b0, 8'h00, 3'd0, 1'b0);
        add(8'h28, 1'b0, 8'h20, 3'd5, 1'b0);
        add(8'h28, 1'b1, 8'h00, 3'd0, 1'b0);
        add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        // Hold timeout: 16 cycles held, forced release, re-grant after one idle.
        add(8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
        for (int k = 0; k < 15; k++)
            add((k % 3 == 0) ? 8'h1F : 8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
        add(8'h10, 1'b0, 8'h00, 3'd0, 1'b1);
        add(8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
        // done on the timeout cycle suppresses the pulse.
        for (int k = 0; k < 15; k++)
            add(8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
        add(8'h10, 1'b1, 8'h00, 3'd0, 1'b0);
        add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

        bus.req  = 8'h00;
        bus.done = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("reset_state", observe(), mk(8'h00, 3'd0, 1'b0));
        #12;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            exp_t e;
            e.grant = vecs[i].grant; e.idx = vecs[i].idx;
            e.valid = vecs[i].valid; e.timeout = vecs[i].timeout;
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].done, e);
        end

        // Asynchronous reset mid-grant, away from any clock edge.
        step("pre_rst_grant", 8'hA4, 1'b0, mk(8'h20, 3'd5, 1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", observe(), mk(8'h00, 3'd0, 1'b0));
        #1;
        rst_n = 1'b1;
        step("post_rst_first", 8'hA4, 1'b0, mk(8'h04, 3'd2, 1'b0));
        step("post_rst_hold", 8'hA4, 1'b0, mk(8'h04, 3'd2, 1'b0));
        step("post_rst_done", 8'hA4, 1'b1, mk(8'h00, 3'd0, 1'b0));
        step("post_rst_next", 8'hA4, 1'b0, mk(8'h20, 3'd5, 1'b0));

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
